// File: rtl/jtkicker_vtgen_pkg.sv
// Shared timing defaults and window/wrap helpers for the Kicker video timing generator.
package jtkicker_vtgen_pkg;

  localparam int VT_W = 9;

  localparam logic [8:0] HCNT_START_D = 9'h080;
  localparam logic [8:0] HCNT_END_D   = 9'h1FF;
  localparam logic [8:0] VCNT_START_D = 9'h0F8;
  localparam logic [8:0] VCNT_END_D   = 9'h1FF;
  localparam logic [8:0] HB_START_D   = 9'h080;
  localparam logic [8:0] HB_END_D     = 9'h100;
  localparam logic [8:0] HS_START_D   = 9'h0A0;
  localparam logic [8:0] HS_END_D     = 9'h0C0;
  localparam logic [8:0] VB_START_D   = 9'h1F0;
  localparam logic [8:0] VB_END_D     = 9'h110;
  localparam logic [8:0] VS_START_D   = 9'h0F8;
  localparam logic [8:0] VS_END_D     = 9'h100;

  // Circular [a,b): when a > b the window runs past the counter end and wraps.
  function automatic logic in_window(int unsigned v, int unsigned a, int unsigned b);
    if (a == b) return 1'b0;
    if (a < b) return (v >= a) && (v < b);
    return (v >= a) || (v < b);
  endfunction

  function automatic int unsigned wrap_add(int unsigned base, int off,
                                           int unsigned lo, int unsigned hi);
    int s;
    int n;
    n = int'(hi - lo) + 1;
    s = int'(base) + off;
    if (s > int'(hi)) s = s - n;
    else if (s < int'(lo)) s = s + n;
    return $unsigned(s);
  endfunction

  function automatic logic in_range(int unsigned v, int unsigned lo, int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/jtkicker_vtgen_cnt.sv
// Range counter: steps START..END and wraps; wrap flags the step that returns to START.
module jtkicker_vtgen_cnt #(
  parameter int             W     = 9,
  parameter logic [W-1:0]   START = '0,
  parameter logic [W-1:0]   END   = '1,
  parameter logic [W-1:0]   INIT  = START
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         step,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = cen & step & (value == END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= INIT;
    else if (cen && step)
      value <= (value == END) ? START : value + W'(1);
  end

endmodule

// File: rtl/jtkicker_vtgen.sv
// Video timing generator: pixel/line counters, render line, blanking, syncs and frame flag.
module jtkicker_vtgen
  import jtkicker_vtgen_pkg::*;
#(
  parameter int           W          = VT_W,
  parameter logic [W-1:0] HCNT_START = W'(HCNT_START_D),
  parameter logic [W-1:0] HCNT_END   = W'(HCNT_END_D),
  parameter logic [W-1:0] VCNT_START = W'(VCNT_START_D),
  parameter logic [W-1:0] VCNT_END   = W'(VCNT_END_D),
  parameter logic [W-1:0] HB_START   = W'(HB_START_D),
  parameter logic [W-1:0] HB_END     = W'(HB_END_D),
  parameter logic [W-1:0] HS_START   = W'(HS_START_D),
  parameter logic [W-1:0] HS_END     = W'(HS_END_D),
  parameter logic [W-1:0] VB_START   = W'(VB_START_D),
  parameter logic [W-1:0] VB_END     = W'(VB_END_D),
  parameter logic [W-1:0] VS_START   = W'(VS_START_D),
  parameter logic [W-1:0] VS_END     = W'(VS_END_D),
  parameter int           VR_LEAD    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pxl_cen,
  input  logic [3:0]   hoffset,
  output logic [W-1:0] hdump,
  output logic [W-1:0] vdump,
  output logic [W-1:0] vrender,
  output logic         hinit,
  output logic         LHBL,
  output logic         LVBL,
  output logic         HS,
  output logic         VS,
  output logic         frame
);

  localparam logic [W-1:0] VR_INIT = W'(wrap_add(32'(VCNT_START), VR_LEAD,
                                                 32'(VCNT_START), 32'(VCNT_END)));

  localparam bit PARAMS_OK =
    (HCNT_START <= HCNT_END) && (VCNT_START <= VCNT_END) &&
    in_range(32'(HB_START), 32'(HCNT_START), 32'(HCNT_END)) &&
    in_range(32'(HB_END),   32'(HCNT_START), 32'(HCNT_END)) &&
    in_range(32'(HS_START), 32'(HCNT_START), 32'(HCNT_END)) &&
    in_range(32'(HS_END),   32'(HCNT_START), 32'(HCNT_END)) &&
    in_range(32'(VB_START), 32'(VCNT_START), 32'(VCNT_END)) &&
    in_range(32'(VB_END),   32'(VCNT_START), 32'(VCNT_END)) &&
    in_range(32'(VS_START), 32'(VCNT_START), 32'(VCNT_END)) &&
    in_range(32'(VS_END),   32'(VCNT_START), 32'(VCNT_END)) &&
    (VR_LEAD >= 0) && (VR_LEAD <= int'(VCNT_END - VCNT_START));

  logic               h_wrap, v_wrap, r_wrap;
  logic [W-1:0]       hdump_nx, vdump_nx, hs_a, hs_b;
  logic signed [3:0]  hoff, hoff_nx;
  logic               hs_nx;

  jtkicker_vtgen_cnt #(.W(W), .START(HCNT_START), .END(HCNT_END)) u_hcnt (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .step(1'b1), .value(hdump), .wrap(h_wrap)
  );

  jtkicker_vtgen_cnt #(.W(W), .START(VCNT_START), .END(VCNT_END)) u_vcnt (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .step(h_wrap), .value(vdump), .wrap(v_wrap)
  );

  jtkicker_vtgen_cnt #(.W(W), .START(VCNT_START), .END(VCNT_END), .INIT(VR_INIT)) u_vrcnt (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .step(h_wrap), .value(vrender), .wrap(r_wrap)
  );

  // Flags are registered from the counters' next values so they line up with hdump/vdump.
  always_comb begin
    hdump_nx = h_wrap ? HCNT_START : hdump + W'(1);
    vdump_nx = v_wrap ? VCNT_START : (h_wrap ? vdump + W'(1) : vdump);
    hoff_nx  = v_wrap ? $signed(hoffset) : hoff;
    hs_a     = W'(wrap_add(32'(HS_START), int'(hoff_nx), 32'(HCNT_START), 32'(HCNT_END)));
    hs_b     = W'(wrap_add(32'(HS_END),   int'(hoff_nx), 32'(HCNT_START), 32'(HCNT_END)));
    hs_nx    = in_window(32'(hdump_nx), 32'(hs_a), 32'(hs_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hinit <= 1'b0;
      LHBL  <= 1'b0;
      LVBL  <= 1'b0;
      HS    <= 1'b0;
      VS    <= 1'b0;
      frame <= 1'b0;
      hoff  <= '0;
    end else if (pxl_cen) begin
      hinit <= (hdump_nx == HCNT_END);
      LHBL  <= ~in_window(32'(hdump_nx), 32'(HB_START), 32'(HB_END));
      HS    <= hs_nx;
      if (hs_nx && !HS)
        VS <= in_window(32'(vdump_nx), 32'(VS_START), 32'(VS_END));
      if (h_wrap)
        LVBL <= ~in_window(32'(vdump_nx), 32'(VB_START), 32'(VB_END));
      if (v_wrap) begin
        frame <= ~frame;
        hoff  <= hoff_nx;
      end
    end
  end

  a_params: assert property (@(posedge clk) PARAMS_OK)
    else $error("jtkicker_vtgen: timing parameter outside counter range");

  a_vr_step: assert property (@(posedge clk) r_wrap |-> h_wrap)
    else $error("jtkicker_vtgen: vrender stepped without a line wrap");

endmodule

// File: tb/tb_jtkicker_vtgen.sv
// Scoreboard bench for jtkicker_vtgen with a shortened 40-line frame (0x1D8..0x1FF).
module tb_jtkicker_vtgen;

  logic       clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
  logic [3:0] hoffset = 4'h0;
  logic [8:0] hdump, vdump, vrender;
  logic       hinit, LHBL, LVBL, HS, VS, frame;

  jtkicker_vtgen #(
    .W(9), .VCNT_START(9'h1D8), .VCNT_END(9'h1FF),
    .VB_START(9'h1F0), .VB_END(9'h1E0), .VS_START(9'h1D8), .VS_END(9'h1E0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .hoffset(hoffset),
    .hdump(hdump), .vdump(vdump), .vrender(vrender), .hinit(hinit),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] hdump, vdump, vrender;
    logic       hinit, lhbl, lvbl, hs, vs, frame;
  } obs_t;

  typedef struct {
    int    due;
    int    agg;
    string tag;
    obs_t  exp;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int vectors = 0, miscompares = 0;
  int agg_hinit_a = 0, agg_hinit_f = 0, lvbl_lines = 0, vs_lines = 0, toggles = 0;
  logic last_frame = 1'b0;

  // Reference model state
  int m_h, m_v, m_hoff;
  bit m_frame, m_vs, m_hs;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t model_obs();
    obs_t o;
    o.hdump   = 9'(m_h);
    o.vdump   = 9'(m_v);
    o.vrender = (m_v == 'h1FF) ? 9'h1D8 : 9'(m_v + 1);
    o.hinit   = (m_h == 'h1FF);
    o.lhbl    = !(m_h >= 'h080 && m_h < 'h100);
    o.lvbl    = !(m_v >= 'h1F0 || m_v < 'h1E0);
    o.hs      = m_hs;
    o.vs      = m_vs;
    o.frame   = m_frame;
    return o;
  endfunction

  function automatic void model_reset();
    m_h = 'h080; m_v = 'h1D8; m_hoff = 0;
    m_frame = 1'b0; m_vs = 1'b0; m_hs = 1'b0;
  endfunction

  function automatic void model_step();
    bit hs_new;
    if (m_h == 'h1FF) begin
      m_h = 'h080;
      if (m_v == 'h1FF) begin
        m_v = 'h1D8;
        m_frame = !m_frame;
        m_hoff = int'($signed(hoffset));
      end else
        m_v = m_v + 1;
    end else
      m_h = m_h + 1;
    hs_new = (m_h >= 'h0A0 + m_hoff) && (m_h < 'h0C0 + m_hoff);
    if (hs_new && !m_hs)
      m_vs = (m_v >= 'h1D8 && m_v < 'h1E0);
    m_hs = hs_new;
  endfunction

  function automatic void push(int due, int agg, string tag);
    item_t it;
    it.due = due; it.agg = agg; it.tag = tag; it.exp = model_obs();
    q.push_back(it);
  endfunction

  task automatic pulse(input int agg, input string tag);
    @(posedge clk); #1;
    pxl_cen = 1'b1;
    model_step();
    push(cyc + 1, agg, tag);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    push(cyc + 1, 0, tag);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares += q.size();
      $display("FAIL drain: %0d expected responses never sampled, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares on the falling edge.
  always @(negedge clk) begin
    item_t it;
    obs_t  act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it  = q.pop_front();
      act = '{hdump, vdump, vrender, hinit, LHBL, LVBL, HS, VS, frame};
      vectors++;
      if (it.due < cyc) begin
        miscompares++;
        $display("FAIL %s: stale expectation due cycle %0d, sampled at %0d", it.tag, it.due, cyc);
      end else if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s @cyc %0d: got h=%h v=%h vr=%h hi=%b hb=%b vb=%b hs=%b vs=%b fr=%b, expected h=%h v=%h vr=%h hi=%b hb=%b vb=%b hs=%b vs=%b fr=%b",
                 it.tag, cyc, act.hdump, act.vdump, act.vrender, act.hinit, act.lhbl, act.lvbl,
                 act.hs, act.vs, act.frame, it.exp.hdump, it.exp.vdump, it.exp.vrender,
                 it.exp.hinit, it.exp.lhbl, it.exp.lvbl, it.exp.hs, it.exp.vs, it.exp.frame);
      end
      if ((it.agg & 1) != 0) agg_hinit_a += int'(act.hinit);
      if ((it.agg & 2) != 0) begin
        agg_hinit_f += int'(act.hinit);
        if (it.exp.hdump == 9'h1FF) begin
          if (!act.lvbl) lvbl_lines++;
          if (act.vs) vs_lines++;
        end
        if (act.frame !== last_frame) toggles++;
      end
      last_frame = act.frame;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 0, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First line: 384 pixels, back to 0x080 with vdump advanced.
    repeat (384) pulse(3, "line0");
    idle("line0_end");
    drain();
    chk("hinit_pulses_line0", agg_hinit_a, 1);

    // Stall mid-line: nothing may move, then counting resumes at the next value.
    while (m_h != 'h150) pulse(2, "to_pause");
    repeat (1000) idle("pause");
    pulse(2, "resume");

    // Mid-frame hoffset change must not touch HS until the next frame.
    while (!(m_v == 'h1E8 && m_h == 'h100)) pulse(2, "frame0");
    hoffset = 4'hC;
    while (!(m_v == 'h1D8 && m_h == 'h080)) pulse(2, "frame0_hoff");
    idle("frame0_end");
    drain();
    chk("frame_toggles", toggles, 1);
    chk("hinit_pulses_frame", agg_hinit_f, 40);
    chk("lvbl_low_lines", lvbl_lines, 24);
    chk("vs_high_lines", vs_lines, 8);

    // Next frame runs with the shifted sync; stop mid-line for the reset test.
    while (!(m_v == 'h1E8 && m_h == 'h150)) pulse(0, "frame1");
    idle("frame1_stop");
    drain();

    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    push(cyc, 0, "async_reset");
    idle("in_reset");
    idle("in_reset");
    rst_n = 1'b1;
    pulse(0, "post_reset");
    idle("post_reset_end");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
